// File: rtl/adc_pulse_capture.sv
// Pulse-width and peak capture on a multi-lane ADC stream: after arming, skips any pulse
// already in progress, then measures one high phase, the following low phase and the high-phase peak.
module adc_pulse_capture #(
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 4
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         i_adc_valid,
    input  logic [SAMPLE_W*LANES-1:0]    i_adc_data,
    input  logic [SAMPLE_W-1:0]          i_threshold,
    input  logic                         i_arm,
    input  logic                         i_stop,
    input  logic [31:0]                  i_timeout,
    output logic [31:0]                  o_data_duration,
    output logic [31:0]                  o_zero_duration,
    output logic [SAMPLE_W-1:0]          o_peak_amp,
    output logic                         o_meas_valid,
    output logic                         o_busy,
    output logic                         o_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        WAIT_HIGH,
        MEAS_HIGH,
        MEAS_LOW
    } state_t;

    state_t                      state_q, state_d;
    logic [31:0]                 high_cnt_q, high_cnt_d;
    logic [31:0]                 low_cnt_q, low_cnt_d;
    logic signed [SAMPLE_W-1:0]  peak_q, peak_d;
    logic [31:0]                 tmo_cnt_q, tmo_cnt_d;
    logic [31:0]                 data_dur_q, data_dur_d;
    logic [31:0]                 zero_dur_q, zero_dur_d;
    logic signed [SAMPLE_W-1:0]  peak_out_q, peak_out_d;
    logic                        meas_valid_q, meas_valid_d;
    logic                        timeout_q, timeout_d;

    logic signed [SAMPLE_W-1:0]  beat_max;
    logic                        beat_high;
    logic                        beat_low;
    logic [31:0]                 tmo_inc;
    logic                        timeout_hit;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A beat is HIGH exactly when its largest lane exceeds the threshold.
    always_comb begin
        beat_max = $signed(i_adc_data[SAMPLE_W-1:0]);
        for (int i = 1; i < LANES; i++) begin
            if ($signed(i_adc_data[i*SAMPLE_W +: SAMPLE_W]) > beat_max) begin
                beat_max = $signed(i_adc_data[i*SAMPLE_W +: SAMPLE_W]);
            end
        end
    end

    assign beat_high   = i_adc_valid && (beat_max > $signed(i_threshold));
    assign beat_low    = i_adc_valid && !(beat_max > $signed(i_threshold));
    assign tmo_inc     = sat_inc(tmo_cnt_q);
    assign timeout_hit = (state_q != IDLE) && (i_timeout != 32'd0) && (tmo_inc >= i_timeout);

    always_comb begin
        state_d      = state_q;
        high_cnt_d   = high_cnt_q;
        low_cnt_d    = low_cnt_q;
        peak_d       = peak_q;
        tmo_cnt_d    = (state_q != IDLE) ? tmo_inc : tmo_cnt_q;
        data_dur_d   = data_dur_q;
        zero_dur_d   = zero_dur_q;
        peak_out_d   = peak_out_q;
        meas_valid_d = 1'b0;
        timeout_d    = 1'b0;

        if (i_stop) begin
            state_d = IDLE;
        end else if (timeout_hit) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_arm) begin
                        state_d   = WAIT_LOW;
                        tmo_cnt_d = 32'd0;
                    end
                end
                WAIT_LOW: begin
                    if (beat_low) state_d = WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (beat_high) begin
                        state_d    = MEAS_HIGH;
                        high_cnt_d = 32'd1;
                        peak_d     = beat_max;
                    end
                end
                MEAS_HIGH: begin
                    if (beat_high) begin
                        high_cnt_d = sat_inc(high_cnt_q);
                        peak_d     = (beat_max > peak_q) ? beat_max : peak_q;
                    end else if (beat_low) begin
                        state_d   = MEAS_LOW;
                        low_cnt_d = 32'd1;
                    end
                end
                MEAS_LOW: begin
                    if (beat_low) begin
                        low_cnt_d = sat_inc(low_cnt_q);
                    end else if (beat_high) begin
                        state_d      = IDLE;
                        data_dur_d   = high_cnt_q;
                        zero_dur_d   = low_cnt_q;
                        peak_out_d   = peak_q;
                        meas_valid_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            high_cnt_q   <= '0;
            low_cnt_q    <= '0;
            peak_q       <= '0;
            tmo_cnt_q    <= '0;
            data_dur_q   <= '0;
            zero_dur_q   <= '0;
            peak_out_q   <= '0;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_cnt_q   <= high_cnt_d;
            low_cnt_q    <= low_cnt_d;
            peak_q       <= peak_d;
            tmo_cnt_q    <= tmo_cnt_d;
            data_dur_q   <= data_dur_d;
            zero_dur_q   <= zero_dur_d;
            peak_out_q   <= peak_out_d;
            meas_valid_q <= meas_valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_data_duration = data_dur_q;
    assign o_zero_duration = zero_dur_q;
    assign o_peak_amp      = peak_out_q;
    assign o_meas_valid    = meas_valid_q;
    assign o_timeout       = timeout_q;
    assign o_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_adc_pulse_capture.sv
// Bench for adc_pulse_capture: directed scenarios plus a random run, all checked every cycle
// against a model that re-parses the list of beats seen since arming.
module tb_adc_pulse_capture;

    localparam int SW = 16;
    localparam int LN = 4;

    logic              sys_clk = 1'b0;
    logic              rst;
    logic              i_adc_valid;
    logic [SW*LN-1:0]  i_adc_data;
    logic [SW-1:0]     i_threshold;
    logic              i_arm;
    logic              i_stop;
    logic [31:0]       i_timeout;
    logic [31:0]       o_data_duration;
    logic [31:0]       o_zero_duration;
    logic [SW-1:0]     o_peak_amp;
    logic              o_meas_valid;
    logic              o_busy;
    logic              o_timeout;

    adc_pulse_capture #(.SAMPLE_W(SW), .LANES(LN)) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .i_adc_valid     (i_adc_valid),
        .i_adc_data      (i_adc_data),
        .i_threshold     (i_threshold),
        .i_arm           (i_arm),
        .i_stop          (i_stop),
        .i_timeout       (i_timeout),
        .o_data_duration (o_data_duration),
        .o_zero_duration (o_zero_duration),
        .o_peak_amp      (o_peak_amp),
        .o_meas_valid    (o_meas_valid),
        .o_busy          (o_busy),
        .o_timeout       (o_timeout)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the beats seen since arming, and the expected registered outputs.
    bit          m_active;
    int unsigned m_cyc;
    bit          hist_h[$];
    int          hist_mx[$];
    logic [31:0] e_dd, e_zd;
    logic [15:0] e_pk;
    bit          e_val, e_to;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] make_beat(input int a, input int b, input int c, input int d);
        logic [15:0] la, lb, lc, ld;
        la = a[15:0];
        lb = b[15:0];
        lc = c[15:0];
        ld = d[15:0];
        return {ld, lc, lb, la};
    endfunction

    function automatic int lane_max(input logic [63:0] d);
        int m;
        int v;
        m = int'($signed(d[15:0]));
        for (int i = 1; i < LN; i++) begin
            v = int'($signed(d[i*16 +: 16]));
            if (v > m) m = v;
        end
        return m;
    endfunction

    // Parse the history: skip a pulse in progress, require a low gap, then high run, low run, rising beat.
    task automatic analyze(output bit done, output int hc, output int lc, output int pk);
        int i;
        int n;
        int hs;
        n  = hist_h.size();
        i  = 0;
        pk = -32768;
        while (i < n && hist_h[i]) i++;
        while (i < n && !hist_h[i]) i++;
        hs = i;
        while (i < n && hist_h[i]) begin
            if (hist_mx[i] > pk) pk = hist_mx[i];
            i++;
        end
        hc = i - hs;
        hs = i;
        while (i < n && !hist_h[i]) i++;
        lc = i - hs;
        done = (i < n) && (hc > 0) && (lc > 0);
    endtask

    task automatic modelStep();
        bit done;
        int hc, lc, pk, mx;
        e_val = 1'b0;
        e_to  = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            e_dd = 0; e_zd = 0; e_pk = 0;
            hist_h.delete(); hist_mx.delete();
        end else if (i_stop) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_cyc++;
            if (i_timeout != 0 && m_cyc >= i_timeout) begin
                m_active = 1'b0;
                e_to     = 1'b1;
            end else if (i_adc_valid) begin
                mx = lane_max(i_adc_data);
                hist_h.push_back(mx > int'($signed(i_threshold)));
                hist_mx.push_back(mx);
                analyze(done, hc, lc, pk);
                if (done) begin
                    e_dd     = hc;
                    e_zd     = lc;
                    e_pk     = pk[15:0];
                    e_val    = 1'b1;
                    m_active = 1'b0;
                end
            end
        end else if (i_arm) begin
            m_active = 1'b1;
            m_cyc    = 0;
            hist_h.delete();
            hist_mx.delete();
        end
    endtask

    task automatic checkAll();
        checkOutput("busy", {31'd0, o_busy}, {31'd0, m_active});
        checkOutput("meas_valid", {31'd0, o_meas_valid}, {31'd0, e_val});
        checkOutput("timeout", {31'd0, o_timeout}, {31'd0, e_to});
        checkOutput("data_duration", o_data_duration, e_dd);
        checkOutput("zero_duration", o_zero_duration, e_zd);
        checkOutput("peak_amp", {16'd0, o_peak_amp}, {16'd0, e_pk});
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic applyStimulus(input bit v, input logic [63:0] d, input bit arm, input bit stop);
        i_adc_valid = v;
        i_adc_data  = d;
        i_arm       = arm;
        i_stop      = stop;
        modelStep();
        @(posedge sys_clk);
        #1;
        checkAll();
    endtask

    logic [63:0] hi_beat, lo_beat;

    task automatic beats(input int n, input bit high, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps) applyStimulus(1'b0, high ? lo_beat : hi_beat, 1'b0, 1'b0);
            applyStimulus(1'b1, high ? hi_beat : lo_beat, 1'b0, 1'b0);
        end
    endtask

    task automatic basicPulse(input bit gaps);
        applyStimulus(1'b1, lo_beat, 1'b1, 1'b0);
        beats(1, 1'b0, gaps);
        beats(5, 1'b1, gaps);
        beats(7, 1'b0, gaps);
        beats(1, 1'b1, gaps);
        checkOutput("pulse_strobe", {31'd0, o_meas_valid}, 32'd1);
        checkOutput("pulse_high_len", o_data_duration, 32'd5);
        checkOutput("pulse_low_len", o_zero_duration, 32'd7);
        checkOutput("pulse_peak", {16'd0, o_peak_amp}, 32'd300);
        applyStimulus(1'b1, lo_beat, 1'b0, 1'b0);
        checkOutput("pulse_idle_after", {31'd0, o_busy}, 32'd0);
        checkOutput("pulse_strobe_once", {31'd0, o_meas_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int thr;
        bit cur_high;
        logic [63:0] nb;
        int lanes[4];

        rst = 1'b1; i_adc_valid = 1'b0; i_adc_data = '0; i_arm = 1'b0; i_stop = 1'b0;
        i_threshold = 16'd100; i_timeout = 32'd0;
        m_active = 1'b0; m_cyc = 0; e_dd = 0; e_zd = 0; e_pk = 0; e_val = 0; e_to = 0;
        hi_beat = make_beat(300, 50, 120, -7);
        lo_beat = make_beat(10, -20, 100, 99);

        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, hi_beat, 1'b1, 1'b0);
        checkOutput("reset_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("reset_dd", o_data_duration, 32'd0);
        rst = 1'b0;

        basicPulse(1'b0);

        // Pulse in progress at arm is skipped.
        applyStimulus(1'b1, hi_beat, 1'b1, 1'b0);
        beats(2, 1'b1, 1'b0);
        beats(2, 1'b0, 1'b0);
        beats(4, 1'b1, 1'b0);
        beats(6, 1'b0, 1'b0);
        beats(1, 1'b1, 1'b0);
        checkOutput("skip_strobe", {31'd0, o_meas_valid}, 32'd1);
        checkOutput("skip_high_len", o_data_duration, 32'd4);
        checkOutput("skip_low_len", o_zero_duration, 32'd6);

        basicPulse(1'b1);

        // Timeout with a constantly low input.
        i_timeout = 32'd20;
        applyStimulus(1'b1, lo_beat, 1'b1, 1'b0);
        n = 0;
        while (!o_timeout && n < 40) begin
            applyStimulus(1'b1, lo_beat, 1'b0, 1'b0);
            n++;
        end
        checkOutput("timeout_latency", n, 32'd20);
        checkOutput("timeout_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("timeout_results", o_data_duration, 32'd5);
        applyStimulus(1'b1, lo_beat, 1'b0, 1'b0);
        checkOutput("timeout_one_cycle", {31'd0, o_timeout}, 32'd0);
        i_timeout = 32'd0;

        // Negative samples, abort in the low phase, then a full negative pulse.
        i_threshold = -16'sd50;
        hi_beat = make_beat(-60, -40, -70, -80);
        lo_beat = make_beat(-100, -50, -90, -51);
        applyStimulus(1'b1, lo_beat, 1'b1, 1'b0);
        beats(1, 1'b0, 1'b0);
        beats(2, 1'b1, 1'b0);
        beats(2, 1'b0, 1'b0);
        applyStimulus(1'b1, lo_beat, 1'b0, 1'b1);
        checkOutput("stop_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("stop_no_strobe", {31'd0, o_meas_valid}, 32'd0);
        applyStimulus(1'b1, lo_beat, 1'b1, 1'b0);
        beats(1, 1'b0, 1'b0);
        beats(1, 1'b1, 1'b0);
        beats(1, 1'b0, 1'b0);
        beats(1, 1'b1, 1'b0);
        checkOutput("neg_peak", {16'd0, o_peak_amp}, {16'd0, 16'hFFD8});

        // Arm and stop together in IDLE stay idle.
        applyStimulus(1'b1, lo_beat, 1'b1, 1'b1);
        checkOutput("arm_stop_idle", {31'd0, o_busy}, 32'd0);

        // Reset mid-measurement, then an immediate re-arm.
        applyStimulus(1'b1, lo_beat, 1'b1, 1'b0);
        beats(1, 1'b0, 1'b0);
        beats(3, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, hi_beat, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midreset_dd", o_data_duration, 32'd0);
        checkOutput("midreset_peak", {16'd0, o_peak_amp}, 32'd0);
        applyStimulus(1'b1, lo_beat, 1'b1, 1'b0);
        beats(3, 1'b1, 1'b0);
        beats(2, 1'b0, 1'b0);
        beats(3, 1'b1, 1'b0);
        beats(4, 1'b0, 1'b0);
        beats(1, 1'b1, 1'b0);
        checkOutput("rearm_high_len", o_data_duration, 32'd3);
        checkOutput("rearm_low_len", o_zero_duration, 32'd4);

        // Random run with persistent high/low segments around a random threshold.
        cur_high = 1'b0;
        thr = int'($urandom_range(0, 2000)) - 1000;
        i_threshold = thr[15:0];
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 7) == 0) cur_high = !cur_high;
            if ($urandom_range(0, 299) == 0) i_timeout = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom_range(30, 300);
            for (int k = 0; k < 4; k++) lanes[k] = thr - int'($urandom_range(0, 300));
            if (cur_high) lanes[$urandom_range(0, 3)] = thr + 1 + int'($urandom_range(0, 400));
            nb = make_beat(lanes[0], lanes[1], lanes[2], lanes[3]);
            rst = ($urandom_range(0, 499) == 0);
            applyStimulus($urandom_range(0, 7) != 0, nb, $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
